// File: rtl/minterm_pkg.sv
// minterm_pkg
// Shared definitions for the minterm scanner: FSM state encoding and
// the dimensions of the 4-variable truth table being scanned.
package minterm_pkg;

   localparam int NVARS = 4;
   localparam int NCOMB = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      EMIT  = 2'd2,
      FIN   = 2'd3
   } state_t;

endpackage

// File: rtl/minterm_scanner_if.sv
// minterm_scanner_if
// Valid/ready stream carrying minterm indices out of the scanner.
//   m_valid : m_index is valid (master -> slave)
//   m_ready : sink accepts m_index (slave -> master)
//   m_index : minterm number, ascending order (master -> slave)
//   m_last  : m_index is the highest minterm of the scan (master -> slave)
interface minterm_scanner_if;
   import minterm_pkg::*;

   logic             m_valid;
   logic             m_ready;
   logic [NVARS-1:0] m_index;
   logic             m_last;

   modport master (
      output m_valid,
      output m_index,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_index,
      input  m_last,
      output m_ready
   );

endinterface

// File: rtl/minterm_emit.sv
// minterm_emit
// Walks the captured truth table from bit 0 upwards and offers each set
// bit as a minterm index on the stream interface.
//   clk, rst_n : clock, asynchronous active-low reset
//   active     : high while the parent FSM is in EMIT
//   tt         : captured truth table
//   finished   : high in the cycle in which pointer 15 is skipped or accepted
//   m_if       : minterm stream (master side)
module minterm_emit
   import minterm_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             active,
   input  logic [NCOMB-1:0] tt,
   output logic             finished,
   minterm_scanner_if.master m_if
);

   localparam logic [NVARS-1:0] LAST_PTR = NVARS'(NCOMB - 1);

   logic [NVARS-1:0] ptr_reg;
   logic [NVARS-1:0] ptr_next;
   logic             hit;
   logic             advance;
   logic [NCOMB-1:0] above_mask;

   // Valid comes only from registered state, so it never depends on m_ready.
   assign hit     = active & tt[ptr_reg];
   // Zero entries are skipped in one cycle; set entries wait for the sink.
   assign advance = active & (~tt[ptr_reg] | m_if.m_ready);

   // above_mask selects the table bits strictly above the pointer.
   genvar gi;
   generate
      for (gi = 0; gi < NCOMB; gi++) begin : g_mask
         assign above_mask[gi] = (NVARS'(gi) > ptr_reg);
      end
   endgenerate

   assign m_if.m_valid = hit;
   assign m_if.m_index = hit ? ptr_reg : '0;
   assign m_if.m_last  = hit & ~|(tt & above_mask);
   assign finished     = advance & (ptr_reg == LAST_PTR);

   // The pointer saturates at 15; the parent leaves EMIT on that step.
   always_comb begin
      ptr_next = ptr_reg;
      if (!active) begin
         ptr_next = '0;
      end else if (advance && (ptr_reg != LAST_PTR)) begin
         ptr_next = ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/minterm_scanner.sv
// minterm_scanner
// Drives all 16 input vectors into an external 4-input function, captures
// its response into a truth table, counts the minterms and then streams the
// minterm indices out in ascending order.
//   SETTLE     : cycles each vector is held before r is sampled (1..15)
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a scan (only honoured in IDLE)
//   x, y, w, z : vector to the function under test (x = bit 3, z = bit 0)
//   r          : combinational response of the function under test
//   busy       : high outside IDLE
//   done       : one-cycle pulse at the end of a scan
//   tt, count  : captured truth table and its number of set bits
//   m_if       : minterm index stream (master side)
module minterm_scanner
   import minterm_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              x,
   output logic              y,
   output logic              w,
   output logic              z,
   input  logic              r,
   output logic              busy,
   output logic              done,
   output logic [NCOMB-1:0]  tt,
   output logic [4:0]        count,
   minterm_scanner_if.master m_if
);

   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [NVARS-1:0] LAST_IDX    = NVARS'(NCOMB - 1);

   state_t           state_reg, state_next;
   logic [NVARS-1:0] idx_reg, idx_next;
   logic [3:0]       settle_reg, settle_next;
   logic [NCOMB-1:0] tt_reg, tt_next;
   logic [4:0]       count_reg, count_next;
   logic             emit_finished;
   logic             settle_last;

   assign settle_last = (settle_reg == SETTLE_LAST);

   minterm_emit u_emit (
      .clk      (clk),
      .rst_n    (rst_n),
      .active   (state_reg == EMIT),
      .tt       (tt_reg),
      .finished (emit_finished),
      .m_if     (m_if)
   );

   always_comb begin
      state_next  = state_reg;
      idx_next    = idx_reg;
      settle_next = settle_reg;
      tt_next     = tt_reg;
      count_next  = count_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next  = APPLY;
               idx_next    = '0;
               settle_next = '0;
               tt_next     = '0;
               count_next  = '0;
            end
         end
         APPLY: begin
            // r is only looked at on the final settle cycle of each vector.
            if (settle_last) begin
               tt_next[idx_reg] = r;
               count_next       = count_reg + 5'(r);
               idx_next         = idx_reg + 1'b1;
               settle_next      = '0;
               if (idx_reg == LAST_IDX) begin
                  state_next = EMIT;
               end
            end else begin
               settle_next = settle_reg + 1'b1;
            end
         end
         EMIT: begin
            if (emit_finished) begin
               state_next = FIN;
            end
         end
         FIN: begin
            // start is deliberately not examined here.
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         idx_reg    <= '0;
         settle_reg <= '0;
         tt_reg     <= '0;
         count_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         idx_reg    <= idx_next;
         settle_reg <= settle_next;
         tt_reg     <= tt_next;
         count_reg  <= count_next;
      end
   end

   assign {x, y, w, z} = (state_reg == APPLY) ? idx_reg : '0;
   assign busy         = (state_reg != IDLE);
   assign done         = (state_reg == FIN);
   assign tt           = tt_reg;
   assign count        = count_reg;

endmodule

// File: tb/tb_minterm_scanner.sv
// tb_minterm_scanner
// Two scanner instances (SETTLE=1 and SETTLE=3) each drive a truth-table
// function held in the bench. r is corrupted with random noise on every
// cycle except the last settle cycle of each vector. Results are checked
// against the function itself: tt = f, count = popcount(f), indices = set
// bits of f in ascending order, m_last only on the highest set bit.
module tb_minterm_scanner;
   import minterm_pkg::*;

   localparam int ND = 2;

   typedef struct {
      int          d;
      logic [15:0] f;
      int          mode;      // 0 ready=1, 1 toggle, 2 random, 3 ready=0
      logic [15:0] exp_tt;
      int          exp_count;
      int          exp_lat;   // edges from start sample to done, 0 = unchecked
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [ND-1:0]        start_a, r_a, x_a, y_a, w_a, z_a, busy_a, done_a;
   logic [ND-1:0]        m_valid_a, m_ready_a, m_last_a, noise_a;
   logic [ND-1:0][3:0]   m_index_a;
   logic [ND-1:0][15:0]  tt_a, f_a;
   logic [ND-1:0][4:0]   count_a;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int mode_a[ND] = '{0, 0};
   int done_cnt[ND];
   int done_cyc[ND];
   int vec15_cnt[ND];
   int got_q[ND][$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int settle_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < ND; gi++) begin : g_dut
         minterm_scanner_if mif ();
         logic [3:0] vec;
         assign vec               = {x_a[gi], y_a[gi], w_a[gi], z_a[gi]};
         assign r_a[gi]           = f_a[gi][vec] ^ noise_a[gi];
         assign mif.m_ready       = m_ready_a[gi];
         assign m_valid_a[gi]     = mif.m_valid;
         assign m_index_a[gi]     = mif.m_index;
         assign m_last_a[gi]      = mif.m_last;
         minterm_scanner #(.SETTLE((gi == 0) ? 1 : 3)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start_a[gi]),
            .x     (x_a[gi]),
            .y     (y_a[gi]),
            .w     (w_a[gi]),
            .z     (z_a[gi]),
            .r     (r_a[gi]),
            .busy  (busy_a[gi]),
            .done  (done_a[gi]),
            .tt    (tt_a[gi]),
            .count (count_a[gi]),
            .m_if  (mif)
         );
      end
   endgenerate

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Sink ready driver.
   initial begin
      m_ready_a = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int d = 0; d < ND; d++) begin
            case (mode_a[d])
               0:       m_ready_a[d] = 1'b1;
               1:       m_ready_a[d] = ~m_ready_a[d];
               2:       m_ready_a[d] = 1'($urandom_range(0, 1));
               default: m_ready_a[d] = 1'b0;
            endcase
         end
      end
   end

   // Monitor and noise generator, evaluated on the falling edge.
   initial begin
      int         hcnt[ND];
      logic [3:0] prev_vec[ND];
      logic       prev_busy[ND];
      logic       stalled[ND];
      logic [3:0] stall_idx[ND];
      logic [3:0] v;
      for (int d = 0; d < ND; d++) begin
         hcnt[d] = 0; prev_vec[d] = '0; prev_busy[d] = 1'b0; stalled[d] = 1'b0; stall_idx[d] = '0;
      end
      noise_a = '0;
      forever begin
         @(negedge clk);
         for (int d = 0; d < ND; d++) begin
            v = {x_a[d], y_a[d], w_a[d], z_a[d]};
            // Position within the hold of the current vector.
            if (busy_a[d] && (!prev_busy[d] || v != prev_vec[d])) hcnt[d] = 0;
            else hcnt[d] = hcnt[d] + 1;
            prev_vec[d]  = v;
            prev_busy[d] = busy_a[d];
            noise_a[d]   = (hcnt[d] == settle_of(d) - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            if (rst_n) begin
               if (stalled[d]) check("hold_index", {m_valid_a[d], m_index_a[d]}, {1'b1, stall_idx[d]});
               if (m_valid_a[d]) begin
                  check("m_last", m_last_a[d], ((f_a[d] >> m_index_a[d]) >> 1) == 16'h0);
                  if (m_ready_a[d]) got_q[d].push_back(int'(m_index_a[d]));
               end else if (m_last_a[d]) begin
                  check("m_last_without_valid", m_last_a[d], 1'b0);
               end
               stalled[d]   = m_valid_a[d] && !m_ready_a[d];
               stall_idx[d] = m_index_a[d];
               if (done_a[d]) begin
                  done_cnt[d]++;
                  done_cyc[d] = cyc;
               end
               if (busy_a[d] && v == 4'hF) vec15_cnt[d]++;
            end else begin
               stalled[d] = 1'b0;
            end
         end
      end
   end

   task automatic clear_obs(input int d);
      got_q[d].delete();
      done_cnt[d]  = 0;
      vec15_cnt[d] = 0;
   endtask

   task automatic check_reset_outputs(input int d, input string name);
      check(name, {tt_a[d], count_a[d], busy_a[d], done_a[d], m_valid_a[d], m_last_a[d],
                   m_index_a[d], x_a[d], y_a[d], w_a[d], z_a[d]}, 64'h0);
   endtask

   task automatic finish_scan(input int d, input logic [15:0] f, input int start_edge,
                              input int exp_lat, input string tag);
      int exp_q[$];
      int n;
      for (int i = 0; i < 4000 && done_cnt[d] == 0; i++) begin
         @(negedge clk);
         #1;
      end
      check({tag, ":done_seen"}, done_cnt[d] != 0, 1'b1);
      check({tag, ":tt"}, tt_a[d], f);
      check({tag, ":count"}, count_a[d], $countones(f));
      for (int i = 0; i < 16; i++) if (f[i]) exp_q.push_back(i);
      check({tag, ":handshakes"}, got_q[d].size(), exp_q.size());
      n = (got_q[d].size() < exp_q.size()) ? got_q[d].size() : exp_q.size();
      for (int k = 0; k < n; k++) check({tag, ":index"}, got_q[d][k], exp_q[k]);
      check({tag, ":vec15_hold"}, vec15_cnt[d], settle_of(d));
      if (exp_lat != 0) check({tag, ":latency"}, done_cyc[d] - start_edge + 1, exp_lat);
      $display("scan %s inst%0d settle=%0d f=%04h tt=%04h count=%0d handshakes=%0d latency=%0d",
               tag, d, settle_of(d), f, tt_a[d], count_a[d], got_q[d].size(),
               done_cyc[d] - start_edge + 1);
   endtask

   task automatic run_scan(input int d, input logic [15:0] f, input int mode, input bit hold,
                           input int exp_lat, input string tag);
      int se;
      f_a[d]    = f;
      mode_a[d] = mode;
      clear_obs(d);
      @(posedge clk);
      #1;
      start_a[d] = 1'b1;
      @(posedge clk);
      #1;
      se = cyc;
      if (!hold) start_a[d] = 1'b0;
      finish_scan(d, f, se, exp_lat, tag);
      if (!hold) begin
         repeat (3) begin
            @(negedge clk);
            #1;
         end
         check({tag, ":single_done"}, done_cnt[d], 1);
         check({tag, ":idle_after"}, busy_a[d], 1'b0);
      end
   endtask

   vec_t tbl[5];

   initial begin
      int          se;
      int          d;
      logic [15:0] f;
      rst_n   = 1'b0;
      start_a = '0;
      f_a     = '0;

      tbl[0] = '{0, 16'h3126, 0, 16'h3126, 6,  33};
      tbl[1] = '{0, 16'h0000, 0, 16'h0000, 0,  33};
      tbl[2] = '{1, 16'hFFFF, 0, 16'hFFFF, 16, 65};
      tbl[3] = '{0, 16'h2B8B, 1, 16'h2B8B, 8,  0};
      tbl[4] = '{1, 16'h0000, 0, 16'h0000, 0,  65};

      #1;
      for (int k = 0; k < ND; k++) check_reset_outputs(k, "reset_state");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed table.
      for (int t = 0; t < 5; t++) begin
         run_scan(tbl[t].d, tbl[t].f, tbl[t].mode, 1'b0, tbl[t].exp_lat, $sformatf("tbl%0d", t));
         check($sformatf("tbl%0d:exp_tt", t), tt_a[tbl[t].d], tbl[t].exp_tt);
         check($sformatf("tbl%0d:exp_count", t), count_a[tbl[t].d], tbl[t].exp_count);
      end

      // Reset while stalled at index 5.
      f_a[0]    = 16'h3120;
      mode_a[0] = 3;
      clear_obs(0);
      @(posedge clk);
      #1;
      start_a[0] = 1'b1;
      @(posedge clk);
      #1;
      start_a[0] = 1'b0;
      for (int i = 0; i < 200 && !m_valid_a[0]; i++) begin
         @(negedge clk);
         #1;
      end
      check("rst:valid_before", m_valid_a[0], 1'b1);
      check("rst:index_before", m_index_a[0], 4'd5);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs(0, "rst:async_outputs");
      repeat (3) @(negedge clk);
      check("rst:no_done", done_cnt[0], 0);
      check_reset_outputs(0, "rst:held_outputs");
      f_a[0]    = 16'h3126;
      mode_a[0] = 0;
      clear_obs(0);
      rst_n      = 1'b1;
      start_a[0] = 1'b1;
      @(posedge clk);
      #1;
      se         = cyc;
      start_a[0] = 1'b0;
      check("rst:start_first_edge", busy_a[0], 1'b1);
      finish_scan(0, 16'h3126, se, 33, "after_rst");

      // start held high for the whole scan.
      repeat (2) @(negedge clk);
      run_scan(0, 16'h3126, 0, 1'b1, 33, "held_start");
      @(negedge clk);
      #1;
      check("held:idle_after_fin", busy_a[0], 1'b0);
      check("held:one_done", done_cnt[0], 1);
      @(negedge clk);
      #1;
      check("held:restart_from_idle", busy_a[0], 1'b1);
      start_a[0] = 1'b0;
      rst_n      = 1'b0;
      #2;
      rst_n = 1'b1;
      @(negedge clk);

      // Randomized scans.
      for (int t = 0; t < 8; t++) begin
         d = int'($urandom_range(0, 1));
         f = 16'($urandom);
         run_scan(d, f, 2, 1'b0, 0, $sformatf("rand%0d", t));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
